// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - Arbitrates EX/ID branch-target updates into a 4-entry coalescing queue that drains into the BTB
module btb_update_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    output logic        ex_ready,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_target,
    output logic        id_ready,
    input  logic        flush,
    input  logic        btb_hold,
    output logic        btb_update_en,
    output logic [31:0] btb_pc,
    output logic [31:0] btb_target,
    output logic [2:0]  pending_cnt
);

    // Queue storage is not reset; validity is tracked only by the pointers and count.
    logic [31:0] pc_mem  [4];
    logic [31:0] tgt_mem [4];

    logic [1:0] rd_q, rd_d;
    logic [1:0] wr_q, wr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] starve_q, starve_d;

    logic        ex_sel, id_sel;
    logic [31:0] req_pc, req_tgt;
    logic        pop;
    logic        hit;
    logic [1:0]  hit_idx;
    logic        accept, enq, coal;

    // Arbitration: EX wins unless ID has waited three cycles in a row.
    always_comb begin
        id_sel  = id_valid && (!ex_valid || (starve_q == 2'd3));
        ex_sel  = ex_valid && !id_sel;
        req_pc  = id_sel ? id_pc : ex_pc;
        req_tgt = id_sel ? id_target : ex_target;
    end

    // The head leaves whenever something is queued and the BTB port is free.
    always_comb begin
        pop = (cnt_q != 3'd0) && !btb_hold && !flush;
    end

    // Look for a queued entry with the same pc; a popping head is not eligible.
    always_comb begin
        logic [1:0] slot;
        hit     = 1'b0;
        hit_idx = rd_q;
        slot    = rd_q;
        for (int k = 3; k >= 0; k--) begin
            slot = rd_q + 2'(k);
            if ((k < int'(cnt_q)) && !(pop && (k == 0)) && (pc_mem[slot] == req_pc)) begin
                hit     = 1'b1;
                hit_idx = slot;
            end
        end
    end

    // A full queue still takes a request that only rewrites an existing entry.
    always_comb begin
        accept   = (ex_sel || id_sel) && !flush && !rst && ((cnt_q != 3'd4) || hit);
        enq      = accept && !hit;
        coal     = accept && hit;
        ex_ready = ex_sel && accept;
        id_ready = id_sel && accept;
    end

    // Next-state for pointers, occupancy and the ID starvation counter.
    always_comb begin
        rd_d     = pop ? rd_q + 2'd1 : rd_q;
        wr_d     = enq ? wr_q + 2'd1 : wr_q;
        cnt_d    = cnt_q + {2'b00, enq} - {2'b00, pop};
        starve_d = starve_q;
        if (id_valid && !id_sel) begin
            if (starve_q != 2'd3) begin
                starve_d = starve_q + 2'd1;
            end
        end else begin
            starve_d = 2'd0;
        end
        if (flush) begin
            rd_d     = 2'd0;
            wr_d     = 2'd0;
            cnt_d    = 3'd0;
            starve_d = 2'd0;
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q     <= 2'd0;
            wr_q     <= 2'd0;
            cnt_q    <= 3'd0;
            starve_q <= 2'd0;
        end else begin
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // Entry write: new requests go to the tail, coalesced ones rewrite the matching target.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_q]  <= req_pc;
            tgt_mem[wr_q] <= req_tgt;
        end else if (coal) begin
            tgt_mem[hit_idx] <= req_tgt;
        end
    end

    // BTB write port shows the head only while it is actually being written.
    always_comb begin
        btb_update_en = pop && !rst;
        btb_pc        = btb_update_en ? pc_mem[rd_q]  : 32'd0;
        btb_target    = btb_update_en ? tgt_mem[rd_q] : 32'd0;
        pending_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - Randomized and directed self-checking bench for btb_update_ctrl
module tb_btb_update_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, id_valid, flush, btb_hold;
    logic [31:0] ex_pc, ex_target, id_pc, id_target;
    logic        ex_ready, id_ready, btb_update_en;
    logic [31:0] btb_pc, btb_target;
    logic [2:0]  pending_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;

    ent_t q[$];
    int   m_starve;

    logic        o_exr, o_idr, o_en;
    logic [31:0] o_pc, o_tgt;
    logic [2:0]  o_cnt;

    btb_update_ctrl dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_target(id_target), .id_ready(id_ready),
        .flush(flush), .btb_hold(btb_hold),
        .btb_update_en(btb_update_en), .btb_pc(btb_pc), .btb_target(btb_target),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, compare against the queue model, then advance the model.
    task automatic step(input logic ev, input logic [31:0] epc, input logic [31:0] etg,
                        input logic iv, input logic [31:0] ipc, input logic [31:0] itg,
                        input logic hold, input logic fl);
        logic        e_pop, ig, eg, e_acc, e_exr, e_idr;
        logic [31:0] rpc, rtg;
        int          mi, sz;
        @(negedge clk);
        ex_valid = ev; ex_pc = epc; ex_target = etg;
        id_valid = iv; id_pc = ipc; id_target = itg;
        btb_hold = hold; flush = fl;
        #1;
        sz    = q.size();
        e_pop = (sz != 0) && !hold && !fl;
        ig    = iv && (!ev || m_starve == 3);
        eg    = ev && !ig;
        rpc   = ig ? ipc : epc;
        rtg   = ig ? itg : etg;
        mi    = -1;
        for (int i = (e_pop ? 1 : 0); i < sz; i++)
            if (mi < 0 && q[i].pc == rpc) mi = i;
        e_acc = (ig || eg) && !fl && (sz < 4 || mi >= 0);
        e_exr = eg && e_acc;
        e_idr = ig && e_acc;
        o_exr = ex_ready; o_idr = id_ready; o_en = btb_update_en;
        o_pc = btb_pc; o_tgt = btb_target; o_cnt = pending_cnt;
        chk("ex_ready", 32'(ex_ready), 32'(e_exr));
        chk("id_ready", 32'(id_ready), 32'(e_idr));
        chk("btb_update_en", 32'(btb_update_en), 32'(e_pop));
        chk("btb_pc", btb_pc, e_pop ? q[0].pc : 32'd0);
        chk("btb_target", btb_target, e_pop ? q[0].tgt : 32'd0);
        chk("pending_cnt", 32'(pending_cnt), sz);
        if (e_acc) begin
            if (mi >= 0) q[mi].tgt = rtg;
            else         q.push_back('{pc: rpc, tgt: rtg});
        end
        if (e_pop) void'(q.pop_front());
        if (fl) begin
            q.delete();
            m_starve = 0;
        end else if (iv && !ig) begin
            if (m_starve < 3) m_starve++;
        end else begin
            m_starve = 0;
        end
    endtask

    task automatic idle(input logic hold);
        step(0, 0, 0, 0, 0, 0, hold, 0);
    endtask

    initial begin
        int hold_pct;
        rst = 1'b1;
        ex_valid = 1; id_valid = 1; flush = 0; btb_hold = 0;
        ex_pc = 32'h10; ex_target = 32'h20; id_pc = 32'h30; id_target = 32'h40;
        m_starve = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ex_ready", 32'(ex_ready), 0);
        chk("rst_id_ready", 32'(id_ready), 0);
        chk("rst_update_en", 32'(btb_update_en), 0);
        chk("rst_btb_pc", btb_pc, 0);
        chk("rst_pending", 32'(pending_cnt), 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Single EX update latency.
        step(1, 32'h100, 32'h200, 0, 0, 0, 0, 0);
        chk("single_ready", 32'(o_exr), 1);
        idle(0);
        chk("single_en", 32'(o_en), 1);
        chk("single_pc", o_pc, 32'h100);
        chk("single_tgt", o_tgt, 32'h200);
        idle(0);
        chk("single_cnt_back", 32'(o_cnt), 0);

        // Fill under hold, fifth is refused, drain in order, then fifth accepted.
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h1000 + 32'(i * 4), 32'h9000 + 32'(i), 0, 0, 0, 1, 0);
            chk("fill_ready", 32'(o_exr), (i < 4) ? 1 : 0);
        end
        chk("fill_cnt", 32'(o_cnt), 4);
        for (int i = 0; i < 4; i++) begin
            idle(0);
            chk("drain_pc", o_pc, 32'h1000 + 32'(i * 4));
            chk("drain_tgt", o_tgt, 32'h9000 + 32'(i));
        end
        step(1, 32'h1010, 32'h9004, 0, 0, 0, 0, 0);
        chk("fifth_ready", 32'(o_exr), 1);
        idle(0);

        // Coalesce onto a queued entry.
        step(1, 32'h40, 32'h80, 0, 0, 0, 1, 0);
        step(1, 32'h44, 32'h90, 0, 0, 0, 1, 0);
        step(1, 32'h44, 32'hA0, 0, 0, 0, 1, 0);
        chk("coal_ready", 32'(o_exr), 1);
        idle(1);
        chk("coal_cnt", 32'(o_cnt), 2);
        idle(0);
        chk("coal_w0_pc", o_pc, 32'h40);
        chk("coal_w0_tgt", o_tgt, 32'h80);
        idle(0);
        chk("coal_w1_pc", o_pc, 32'h44);
        chk("coal_w1_tgt", o_tgt, 32'hA0);
        idle(0);

        // Starvation pattern: EX x3 then ID, repeating.
        for (int i = 0; i < 8; i++) begin
            step(1, 32'h2000 + 32'(i * 4), 32'h1, 1, 32'h3000 + 32'(i * 4), 32'h2, 0, 0);
            chk("starve_ex", 32'(o_exr), (i % 4 == 3) ? 0 : 1);
            chk("starve_id", 32'(o_idr), (i % 4 == 3) ? 1 : 0);
        end
        idle(0);
        idle(0);

        // Flush with three entries queued under hold.
        for (int i = 0; i < 3; i++) step(1, 32'h600 + 32'(i * 4), 32'h7, 0, 0, 0, 1, 0);
        step(1, 32'h700, 32'h8, 0, 0, 0, 1, 1);
        chk("flush_ready", 32'(o_exr), 0);
        chk("flush_en", 32'(o_en), 0);
        idle(1);
        chk("flush_cnt", 32'(o_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            idle(0);
            chk("flush_no_write", 32'(o_en), 0);
        end

        // Asynchronous reset between clock edges with two entries queued.
        step(1, 32'h800, 32'h1, 0, 0, 0, 1, 0);
        step(1, 32'h804, 32'h2, 0, 0, 0, 1, 0);
        idle(0);
        chk("prereset_en", 32'(o_en), 1);
        rst = 1'b1;
        #1;
        chk("async_en", 32'(btb_update_en), 0);
        chk("async_cnt", 32'(pending_cnt), 0);
        chk("async_pc", btb_pc, 0);
        q.delete();
        m_starve = 0;
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 1, 32'h900, 32'h901, 0, 0);
        chk("post_reset_grant", 32'(o_idr), 1);

        // Randomized traffic with a small pc pool so coalescing and fullness occur.
        hold_pct = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) hold_pct = $urandom_range(0, 9);
            step(($urandom % 10) < 6, 32'h500 + 32'(($urandom % 6) * 4), $urandom,
                 ($urandom % 10) < 5, 32'h500 + 32'(($urandom % 6) * 4), $urandom,
                 ($urandom % 10) < hold_pct, ($urandom % 50) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
